reg_wb_queue: RTL

- Write-side producer for the 32x32 register file. It accepts results from two sources, the ALU and the load unit, over valid/ready handshakes.
- Accepted results go into an in-order queue. One queued write is drained per cycle onto the register file write port (rf_wen/rf_waddr/rf_wdata).
- It publishes a pending-write scoreboard and two bypass lookup ports. Readers can therefore get the youngest not-yet-committed value for a register.

---
 rtl/reg_wb_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/reg_wb_queue.sv
// Register-file write-back queue.
// Collects ALU and load results into a small in-order circular buffer and
// drains one entry per cycle onto the register-file write port. It also
// exposes a pending-write scoreboard and two bypass lookup ports that return
// the youngest not-yet-committed value for a register.
module reg_wb_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_WIDTH-1:0]      alu_waddr,
    input  logic [DATA_WIDTH-1:0]      alu_wdata,

    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_WIDTH-1:0]      mem_waddr,
    input  logic [DATA_WIDTH-1:0]      mem_wdata,

    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,

    output logic [(1<<ADDR_WIDTH)-1:0] busy,

    input  logic [ADDR_WIDTH-1:0]      byp_raddr1,
    input  logic [ADDR_WIDTH-1:0]      byp_raddr2,
    output logic                       byp_hit1,
    output logic                       byp_hit2,
    output logic [DATA_WIDTH-1:0]      byp_data1,
    output logic [DATA_WIDTH-1:0]      byp_data2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  alu_push;
    logic                  mem_push;
    logic                  pop;
    logic [PTR_W-1:0]      mem_slot;

    // Ready depends only on the registered occupancy; a pop in the same cycle
    // does not free space early. Writes to r0 are accepted but take no slot,
    // so they do not reduce the space offered to the load port.
    assign alu_ready = (count < CNT_W'(DEPTH));
    assign alu_push  = alu_valid && alu_ready && (alu_waddr != '0);
    assign mem_ready = ((count + CNT_W'(alu_push)) < CNT_W'(DEPTH));
    assign mem_push  = mem_valid && mem_ready && (mem_waddr != '0);
    assign pop       = (count != '0);

    // The load entry lands behind the ALU entry when both push together.
    assign mem_slot  = tail + PTR_W'(alu_push);

    // Head entry is presented to the register file whenever the queue is not empty.
    assign rf_wen   = pop;
    assign rf_waddr = pop ? q_addr[head] : '0;
    assign rf_wdata = pop ? q_data[head] : '0;

    // Entry storage: write accepted results into their slots, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (alu_push) begin
                q_addr[tail] <= alu_waddr;
                q_data[tail] <= alu_wdata;
            end
            if (mem_push) begin
                q_addr[mem_slot] <= mem_waddr;
                q_data[mem_slot] <= mem_wdata;
            end
        end
    end

    // Pointer and occupancy bookkeeping; the head entry commits on every non-empty edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(alu_push) + PTR_W'(mem_push);
            head  <= head + PTR_W'(pop);
            count <= count + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);
        end
    end

    // Scan valid entries oldest to youngest so the last match is the youngest.
    always_comb begin
        busy      = '0;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                busy[q_addr[head + PTR_W'(i)]] = 1'b1;
                if ((byp_raddr1 != '0) && (q_addr[head + PTR_W'(i)] == byp_raddr1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = q_data[head + PTR_W'(i)];
                end
                if ((byp_raddr2 != '0) && (q_addr[head + PTR_W'(i)] == byp_raddr2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = q_data[head + PTR_W'(i)];
                end
            end
        end
        busy[0] = 1'b0;
    end

endmodule
